// File: rtl/sync_hold_launcher.sv
// sync_hold_launcher: source-domain launcher for a multi-bit clock-domain crossing.
// Takes a word over valid/ready and places it on a registered launch bus. After
// SETTLE cycles it flips a toggle strobe, then keeps the bus frozen for HOLD cycles
// before it accepts another word.
// Optional feature macro: SYNC_LAUNCH_PARITY_EN adds launch_par, the even parity of the word.
module sync_hold_launcher #(
  parameter int WIDTH  = 16,
  parameter int SETTLE = 2,
  parameter int HOLD   = 6
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] launch_dat,
  output logic             launch_tog,
  output logic             busy
`ifdef SYNC_LAUNCH_PARITY_EN
  ,
  output logic             launch_par
`endif
);

  localparam int MAXC = (SETTLE > HOLD) ? SETTLE : HOLD;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD - 1);

  // Both windows need at least one cycle, or the far side could sample a moving bus
  if (SETTLE < 1 || HOLD < 1) begin : g_param_check
    $error("sync_hold_launcher: SETTLE and HOLD must both be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HOLD
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [WIDTH-1:0] dat_nxt;
  logic            tog_nxt;
  logic            ready_nxt;
`ifdef SYNC_LAUNCH_PARITY_EN
  logic            par_nxt;
`endif

  // Next-state and next-output logic; the bus only moves on a load edge
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dat_nxt   = launch_dat;
    tog_nxt   = launch_tog;
    ready_nxt = din_ready;
`ifdef SYNC_LAUNCH_PARITY_EN
    par_nxt   = launch_par;
`endif
    case (state)
      ST_IDLE: begin
        if (din_valid && din_ready) begin
          dat_nxt   = din;
`ifdef SYNC_LAUNCH_PARITY_EN
          par_nxt   = ^din;
`endif
          ready_nxt = 1'b0;
          cnt_nxt   = SETTLE_LD;
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt == '0) begin
          tog_nxt   = ~launch_tog;
          cnt_nxt   = HOLD_LD;
          state_nxt = ST_HOLD;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          ready_nxt = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
        ready_nxt = 1'b1;
      end
    endcase
  end

  // State and output registers; reset drops any pending toggle immediately
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      launch_dat <= '0;
      launch_tog <= 1'b0;
      din_ready  <= 1'b1;
      busy       <= 1'b0;
`ifdef SYNC_LAUNCH_PARITY_EN
      launch_par <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      launch_dat <= dat_nxt;
      launch_tog <= tog_nxt;
      din_ready  <= ready_nxt;
      busy       <= ~ready_nxt;
`ifdef SYNC_LAUNCH_PARITY_EN
      launch_par <= par_nxt;
`endif
    end
  end

endmodule
